div_err_monitor: RTL and testbench

Sequential error-characterisation stage placed directly downstream of the 16/8 approximate array divider. For each operand set it captures the divider inputs and the approximate quotient and remainder, and computes the exact result with an internal radix-2 restoring iterative divider. It then accumulates error statistics (mismatch counts, summed and maximum quotient error distance) for reporting how accurate the approximate divider is.

---
 rtl/div_err_monitor.sv | 197 +++++++++++++++++++
 tb/tb_div_err_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_err_monitor.sv
// Error monitor for the 16/8 approximate divider: computes the exact quotient/remainder and accumulates error stats.
// Latency: in-domain sample commits 9 cycles after accept (DIV x8 + CMP); out-of-domain sample commits 1 cycle after accept.
// Backpressure: in_ready is high only in IDLE; in_valid while busy is dropped, nothing is queued.
module div_err_monitor #(
    parameter int CNT_W = 32,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      x,
    input  logic [7:0]       y,
    input  logic [7:0]       q_app,
    input  logic [7:0]       r_app,
    input  logic             clear,
    output logic             done,
    output logic [7:0]       q_exact,
    output logic [7:0]       r_exact,
    output logic [7:0]       ed_last,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [CNT_W-1:0] q_err_cnt,
    output logic [CNT_W-1:0] r_err_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [7:0]       ed_max
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SKIP = 2'd1,
        S_DIV  = 2'd2,
        S_CMP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched sample. Only the low dividend byte is needed after accept:
    // the high byte seeds the partial remainder directly.
    logic [7:0] r_xlo;
    logic [7:0] r_y;
    logic [7:0] r_q_app;
    logic [7:0] r_r_app;

    // Restoring divider state. PR always stays below y, so 8 bits suffice;
    // only the trial value T needs the 9th bit.
    logic [7:0] r_pr;
    logic [7:0] r_quo;
    logic [2:0] r_iter;

    logic [7:0]       r_q_exact;
    logic [7:0]       r_r_exact;
    logic [7:0]       r_ed_last;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_skip_cnt;
    logic [CNT_W-1:0] r_q_err_cnt;
    logic [CNT_W-1:0] r_r_err_cnt;
    logic [ACC_W-1:0] r_ed_sum;
    logic [7:0]       r_ed_max;

    logic           w_out_of_domain;
    logic [2:0]     w_idx;
    logic           w_xbit;
    logic [8:0]     w_t;
    logic           w_ge;
    logic [7:0]     w_sub;
    logic [7:0]     w_ed;
    logic [ACC_W:0] w_sum;

    // Quotient would not fit in 8 bits (or divide by zero).
    assign w_out_of_domain = (y == 8'd0) || (x[15:8] >= y);

    // One restoring step per DIV cycle, dividend bits MSB first.
    assign w_idx  = 3'd7 - r_iter;
    assign w_xbit = r_xlo[w_idx];
    assign w_t    = {r_pr, w_xbit};
    assign w_ge   = (w_t >= {1'b0, r_y});
    // T - y < y <= 255 whenever T >= y, so the low 8 bits are exact.
    assign w_sub  = w_t[7:0] - r_y;

    // Error distance, valid in CMP when r_quo holds the final quotient.
    assign w_ed  = (r_quo >= r_q_app) ? (r_quo - r_q_app) : (r_q_app - r_quo);
    assign w_sum = {1'b0, r_ed_sum} + (ACC_W+1)'(w_ed);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? (v + 1'b1) : v;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode plus handshake and commit strobe.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = w_out_of_domain ? S_SKIP : S_DIV;
            end
            S_SKIP: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_DIV: begin
                if (r_iter == 3'd7) w_next = S_CMP;
            end
            S_CMP: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Sample capture and iterative division datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xlo   <= 8'd0;
            r_y     <= 8'd0;
            r_q_app <= 8'd0;
            r_r_app <= 8'd0;
            r_pr    <= 8'd0;
            r_quo   <= 8'd0;
            r_iter  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_xlo   <= x[7:0];
                        r_y     <= y;
                        r_q_app <= q_app;
                        r_r_app <= r_app;
                        r_pr    <= x[15:8];
                        r_quo   <= 8'd0;
                        r_iter  <= 3'd0;
                    end
                end
                S_DIV: begin
                    r_pr   <= w_ge ? w_sub : w_t[7:0];
                    r_quo  <= {r_quo[6:0], w_ge};
                    r_iter <= r_iter + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Per-sample results; clear leaves these alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_exact <= 8'd0;
            r_r_exact <= 8'd0;
            r_ed_last <= 8'd0;
        end else if (r_state == S_CMP) begin
            r_q_exact <= r_quo;
            r_r_exact <= r_pr;
            r_ed_last <= w_ed;
        end
    end

    // Saturating statistics; clear takes priority over a same-cycle commit.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_sample_cnt <= '0;
            r_skip_cnt   <= '0;
            r_q_err_cnt  <= '0;
            r_r_err_cnt  <= '0;
            r_ed_sum     <= '0;
            r_ed_max     <= 8'd0;
        end else if (r_state == S_SKIP) begin
            r_skip_cnt <= sat_inc(r_skip_cnt, 1'b1);
        end else if (r_state == S_CMP) begin
            r_sample_cnt <= sat_inc(r_sample_cnt, 1'b1);
            r_q_err_cnt  <= sat_inc(r_q_err_cnt, w_ed != 8'd0);
            r_r_err_cnt  <= sat_inc(r_r_err_cnt, r_r_app != r_pr);
            r_ed_sum     <= w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
            if (w_ed > r_ed_max) r_ed_max <= w_ed;
        end
    end

    assign q_exact    = r_q_exact;
    assign r_exact    = r_r_exact;
    assign ed_last    = r_ed_last;
    assign sample_cnt = r_sample_cnt;
    assign skip_cnt   = r_skip_cnt;
    assign q_err_cnt  = r_q_err_cnt;
    assign r_err_cnt  = r_r_err_cnt;
    assign ed_sum     = r_ed_sum;
    assign ed_max     = r_ed_max;

endmodule

// File: tb/tb_div_err_monitor.sv
// Directed bench for div_err_monitor with hand-computed expectations.
// Counters narrowed to 4 bits so saturation is reachable in a short run.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_div_err_monitor;

    localparam int CNT_W = 4;
    localparam int ACC_W = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      x;
    logic [7:0]       y;
    logic [7:0]       q_app;
    logic [7:0]       r_app;
    logic             clear;
    logic             done;
    logic [7:0]       q_exact;
    logic [7:0]       r_exact;
    logic [7:0]       ed_last;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] skip_cnt;
    logic [CNT_W-1:0] q_err_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [ACC_W-1:0] ed_sum;
    logic [7:0]       ed_max;

    int n_vec = 0;
    int n_err = 0;

    div_err_monitor #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .q_app(q_app), .r_app(r_app), .clear(clear),
        .done(done), .q_exact(q_exact), .r_exact(r_exact), .ed_last(ed_last),
        .sample_cnt(sample_cnt), .skip_cnt(skip_cnt), .q_err_cnt(q_err_cnt),
        .r_err_cnt(r_err_cnt), .ed_sum(ed_sum), .ed_max(ed_max)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string tag, input int s, input int k, input int qe,
                             input int re, input longint sum, input int mx);
        chk({tag, ".sample_cnt"}, sample_cnt, s);
        chk({tag, ".skip_cnt"},   skip_cnt,   k);
        chk({tag, ".q_err_cnt"},  q_err_cnt,  qe);
        chk({tag, ".r_err_cnt"},  r_err_cnt,  re);
        chk({tag, ".ed_sum"},     ed_sum,     sum);
        chk({tag, ".ed_max"},     ed_max,     mx);
    endtask

    // Present one sample in the current (IDLE) cycle, accept on the next edge,
    // then scramble the inputs so latching is exercised.
    task automatic start(input logic [15:0] xv, input logic [7:0] yv,
                         input logic [7:0] qa, input logic [7:0] ra);
        x = xv; y = yv; q_app = qa; r_app = ra;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        x = ~xv; y = ~yv; q_app = ~qa; r_app = ~ra;
    endtask

    // Leaves the bench in the done cycle; cycle 1 is the first after accept.
    task automatic wait_done(input string tag, input int exp_lat);
        int cyc = 1;
        while (!done && cyc < 30) begin
            step();
            cyc++;
        end
        chk({tag, ".latency"}, cyc, exp_lat);
    endtask

    task automatic run_sample(input string tag, input logic [15:0] xv, input logic [7:0] yv,
                              input logic [7:0] qa, input logic [7:0] ra, input int exp_lat);
        start(xv, yv, qa, ra);
        wait_done(tag, exp_lat);
        step();
        chk({tag, ".done_one_cycle"}, done, 1'b0);
        chk({tag, ".ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0;
        x = 16'h0; y = 8'h0; q_app = 8'h0; r_app = 8'h0;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.done", done, 1'b0);
        chk("rst.q_exact", q_exact, 8'h0);
        chk("rst.r_exact", r_exact, 8'h0);
        chk("rst.ed_last", ed_last, 8'h0);
        chk_stats("rst", 0, 0, 0, 0, 0, 0);

        // 4660 / 86 = 54 rem 16
        run_sample("exact", 16'h1234, 8'h56, 8'h36, 8'h10, 9);
        chk("exact.q_exact", q_exact, 8'h36);
        chk("exact.r_exact", r_exact, 8'h10);
        chk("exact.ed_last", ed_last, 8'h00);
        chk_stats("exact", 1, 0, 0, 0, 0, 0);

        run_sample("err2", 16'h1234, 8'h56, 8'h34, 8'hBC, 9);
        chk("err2.ed_last", ed_last, 8'd2);
        chk_stats("err2", 2, 0, 1, 1, 2, 2);

        run_sample("err5", 16'h1234, 8'h56, 8'h31, 8'h10, 9);
        chk("err5.ed_last", ed_last, 8'd5);
        chk_stats("err5", 3, 0, 2, 1, 7, 5);

        // Approximation above exact: ed = 0x39 - 0x36 = 3
        run_sample("err3hi", 16'h1234, 8'h56, 8'h39, 8'h10, 9);
        chk("err3hi.ed_last", ed_last, 8'd3);
        chk_stats("err3hi", 4, 0, 3, 1, 10, 5);

        // 255 / 1 = 255 rem 0
        run_sample("y1", 16'h00FF, 8'h01, 8'hFF, 8'h00, 9);
        chk("y1.q_exact", q_exact, 8'hFF);
        chk("y1.r_exact", r_exact, 8'h00);
        chk_stats("y1", 5, 0, 3, 1, 10, 5);

        // 65279 / 255 = 255 rem 254, largest in-domain dividend for y=255
        run_sample("max", 16'hFEFF, 8'hFF, 8'h00, 8'h00, 9);
        chk("max.q_exact", q_exact, 8'hFF);
        chk("max.r_exact", r_exact, 8'hFE);
        chk("max.ed_last", ed_last, 8'hFF);
        chk_stats("max", 6, 0, 4, 2, 265, 255);

        // Out of domain: x[15:8] == y, then y == 0
        run_sample("skip_eq", 16'h5600, 8'h56, 8'h00, 8'h00, 1);
        chk_stats("skip_eq", 6, 1, 4, 2, 265, 255);
        chk("skip_eq.q_exact_held", q_exact, 8'hFF);
        chk("skip_eq.ed_last_held", ed_last, 8'hFF);
        run_sample("skip_y0", 16'h0012, 8'h00, 8'h00, 8'h00, 1);
        chk_stats("skip_y0", 6, 2, 4, 2, 265, 255);

        // Clear while idle
        clear = 1'b1; step(); clear = 1'b0;
        chk_stats("clr_idle", 0, 0, 0, 0, 0, 0);
        chk("clr_idle.q_exact_held", q_exact, 8'hFF);

        // Backpressure: new operands offered in cycles 3..9 are dropped
        begin
            int ndone = 0;
            int nready = 0;
            logic prev_done = 1'b0;
            int dbl = 0;
            start(16'h1234, 8'h56, 8'h34, 8'h10);
            for (int c = 1; c <= 14; c++) begin
                if (c >= 3 && c <= 9) begin
                    x = 16'h0100; y = 8'h02; q_app = 8'h80; r_app = 8'h00;
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                if (done) ndone++;
                if (done && prev_done) dbl++;
                if (c <= 9 && in_ready) nready++;
                prev_done = done;
                step();
            end
            in_valid = 1'b0;
            chk("bp.done_pulses", ndone, 1);
            chk("bp.back_to_back", dbl, 0);
            chk("bp.ready_while_busy", nready, 0);
            chk("bp.q_exact", q_exact, 8'h36);
            chk("bp.ed_last", ed_last, 8'd2);
            chk_stats("bp", 1, 0, 1, 0, 2, 2);
        end

        // Clear in the CMP cycle: clear wins, per-sample results still update
        start(16'h1234, 8'h56, 8'h39, 8'h10);
        wait_done("clr_cmp", 9);
        clear = 1'b1; step(); clear = 1'b0;
        chk_stats("clr_cmp", 0, 0, 0, 0, 0, 0);
        chk("clr_cmp.ed_last", ed_last, 8'd3);
        chk("clr_cmp.q_exact", q_exact, 8'h36);

        // Clear mid-division: the in-flight sample lands in cleared stats
        run_sample("pre_skip", 16'hFF00, 8'h10, 8'h00, 8'h00, 1);
        chk("pre_skip.skip_cnt", skip_cnt, 1);
        start(16'h1234, 8'h56, 8'h35, 8'h10);
        step(); step(); step();
        clear = 1'b1; step(); clear = 1'b0;
        wait_done("clr_mid", 5);
        step();
        chk_stats("clr_mid", 1, 0, 1, 0, 1, 1);
        chk("clr_mid.ed_last", ed_last, 8'd1);

        // Reset in cycle 5 of a division
        begin
            int ndone = 0;
            start(16'h00FF, 8'h01, 8'h00, 8'h00);
            step(); step(); step(); step();
            rst = 1'b1; step(); rst = 1'b0;
            chk("rstmid.in_ready", in_ready, 1'b1);
            chk("rstmid.done", done, 1'b0);
            chk("rstmid.q_exact", q_exact, 8'h0);
            chk("rstmid.ed_last", ed_last, 8'h0);
            chk_stats("rstmid", 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 10; c++) begin
                if (done) ndone++;
                step();
            end
            chk("rstmid.no_done", ndone, 0);
        end
        run_sample("fresh", 16'h1234, 8'h56, 8'h36, 8'h10, 9);
        chk("fresh.q_exact", q_exact, 8'h36);
        chk_stats("fresh", 1, 0, 0, 0, 0, 0);

        // Saturation: 17 error samples on top of one exact sample
        for (int i = 0; i < 17; i++) run_sample("sat", 16'h1234, 8'h56, 8'h34, 8'hBC, 9);
        chk_stats("sat", 15, 0, 15, 15, 34, 2);
        for (int i = 0; i < 17; i++) run_sample("satskip", 16'h0000, 8'h00, 8'h00, 8'h00, 1);
        chk("satskip.skip_cnt", skip_cnt, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
